// File: rtl/inst_fetch_queue.sv
// Circular instruction/PC queue between the dual-issue fetch stage and decode.
// Define FQ_BYPASS_EN to let a bundle arriving at an empty queue drive the outputs in the same cycle.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [31:0]      in_inst1,
  input  logic [31:0]      in_inst2,
  input  logic [31:0]      in_PC1,
  input  logic [31:0]      in_PC2,
  output logic             in_stall,
  input  logic             flush,
  input  logic [1:0]       deq_num,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic [31:0]      out_inst1,
  output logic [31:0]      out_inst2,
  output logic [31:0]      out_PC1,
  output logic [31:0]      out_PC2,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CW = PTR_W + 1;
  localparam logic [CW-1:0] FullThr = CW'(DEPTH - 2);

  logic [31:0]      r_mem_inst [DEPTH];
  logic [31:0]      r_mem_pc   [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CW-1:0]    r_count;

  logic [PTR_W-1:0] w_head_d, w_tail_d, w_head_p1, w_base;
  logic [CW-1:0]    w_count_d;
  logic             w_enq;
  logic [1:0]       w_deq_req, w_deq_eff;
  logic [1:0]       w_wr_en;
  logic [PTR_W-1:0] w_wr_idx0, w_wr_idx1;
  logic [31:0]      w_wr_inst0, w_wr_pc0, w_wr_inst1, w_wr_pc1;

  // Stall depends on registered count only, so a same-cycle dequeue never frees room.
  assign in_stall  = r_count > FullThr;
  assign w_enq     = in_valid && !in_stall;
  assign w_deq_req = (deq_num == 2'd3) ? 2'd2 : deq_num;
  assign w_deq_eff = (r_count < CW'(w_deq_req)) ? r_count[1:0] : w_deq_req;
  assign w_head_p1 = r_head + PTR_W'(1);
  assign w_base    = flush ? '0 : r_tail;
  assign count     = r_count;

`ifdef FQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_enq && (flush || (r_count == '0));
`endif

  always_comb begin
    w_head_d   = r_head;
    w_tail_d   = r_tail;
    w_count_d  = r_count;
    w_wr_en    = 2'b00;
    w_wr_idx0  = w_base;
    w_wr_idx1  = w_base + PTR_W'(1);
    w_wr_inst0 = in_inst1;
    w_wr_pc0   = in_PC1;
    w_wr_inst1 = in_inst2;
    w_wr_pc1   = in_PC2;

    if (flush) begin
      w_head_d  = '0;
      w_tail_d  = '0;
      w_count_d = '0;
    end else begin
      w_head_d  = r_head + PTR_W'(w_deq_eff);
      w_count_d = r_count - CW'(w_deq_eff);
    end

    if (w_enq) begin
`ifdef FQ_BYPASS_EN
      if (w_bypass) begin
        // Decode takes the first k bundle instructions directly; only the rest is stored.
        unique case (w_deq_req)
          2'd0: begin
            w_wr_en   = 2'b11;
            w_tail_d  = w_base + PTR_W'(2);
            w_count_d = CW'(2);
          end
          2'd1: begin
            w_wr_en    = 2'b01;
            w_wr_inst0 = in_inst2;
            w_wr_pc0   = in_PC2;
            w_tail_d   = w_base + PTR_W'(1);
            w_count_d  = CW'(1);
          end
          default: begin
            w_tail_d  = w_base;
            w_count_d = '0;
          end
        endcase
      end else
`endif
      begin
        w_wr_en   = 2'b11;
        w_tail_d  = w_base + PTR_W'(2);
        w_count_d = w_count_d + CW'(2);
      end
    end
  end

  always_comb begin
    out_valid1 = r_count != '0;
    out_valid2 = r_count > CW'(1);
    out_inst1  = out_valid1 ? r_mem_inst[r_head]    : '0;
    out_PC1    = out_valid1 ? r_mem_pc[r_head]      : '0;
    out_inst2  = out_valid2 ? r_mem_inst[w_head_p1] : '0;
    out_PC2    = out_valid2 ? r_mem_pc[w_head_p1]   : '0;
`ifdef FQ_BYPASS_EN
    if (w_bypass) begin
      out_valid1 = 1'b1;
      out_valid2 = 1'b1;
      out_inst1  = in_inst1;
      out_PC1    = in_PC1;
      out_inst2  = in_inst2;
      out_PC2    = in_PC2;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_d;
      r_tail  <= w_tail_d;
      r_count <= w_count_d;
    end
  end

  // Storage carries no reset; entries are only observable once counted.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (w_wr_en[0]) begin
        r_mem_inst[w_wr_idx0] <= w_wr_inst0;
        r_mem_pc[w_wr_idx0]   <= w_wr_pc0;
      end
      if (w_wr_en[1]) begin
        r_mem_inst[w_wr_idx1] <= w_wr_inst1;
        r_mem_pc[w_wr_idx1]   <= w_wr_pc1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=8); covers fill, stall,
// wrap, flush and the FQ_BYPASS_EN same-cycle path when that macro is defined.
module tb_inst_fetch_queue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic [31:0] in_inst1, in_inst2, in_PC1, in_PC2;
  logic        in_stall;
  logic        flush;
  logic [1:0]  deq_num;
  logic        out_valid1, out_valid2;
  logic [31:0] out_inst1, out_inst2, out_PC1, out_PC2;
  logic [3:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_queue #(.DEPTH(8), .PTR_W(3)) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_inst1  (in_inst1),
    .in_inst2  (in_inst2),
    .in_PC1    (in_PC1),
    .in_PC2    (in_PC2),
    .in_stall  (in_stall),
    .flush     (flush),
    .deq_num   (deq_num),
    .out_valid1(out_valid1),
    .out_valid2(out_valid2),
    .out_inst1 (out_inst1),
    .out_inst2 (out_inst2),
    .out_PC1   (out_PC1),
    .out_PC2   (out_PC2),
    .count     (count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h0013_0000 ^ pc;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] p1, input logic [31:0] p2,
                       input logic fl, input logic [1:0] dq);
    in_valid = v;
    in_PC1   = p1;
    in_PC2   = p2;
    in_inst1 = inst_of(p1);
    in_inst2 = inst_of(p2);
    flush    = fl;
    deq_num  = dq;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    tick();
    tick();
    RST = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_stall", 32'(in_stall), 32'd0);
    check("rst_v1", 32'(out_valid1), 32'd0);
    check("rst_v2", 32'(out_valid2), 32'd0);
    check("rst_inst1", out_inst1, 32'd0);
    check("rst_pc1", out_PC1, 32'd0);

    // Three bundles, no dequeue
    drive(1'b1, 32'd4, 32'd8, 1'b0, 2'd0);   tick();
    check("b1_count", 32'(count), 32'd2);
    drive(1'b1, 32'd12, 32'd16, 1'b0, 2'd0); tick();
    drive(1'b1, 32'd20, 32'd24, 1'b0, 2'd0); tick();
    check("b3_count", 32'(count), 32'd6);
    check("b3_pc1", out_PC1, 32'd4);
    check("b3_pc2", out_PC2, 32'd8);
    check("b3_inst1", out_inst1, inst_of(32'd4));
    check("b3_stall", 32'(in_stall), 32'd0);

    // Fill to DEPTH, then an ignored bundle
    drive(1'b1, 32'd28, 32'd32, 1'b0, 2'd0); tick();
    check("full_count", 32'(count), 32'd8);
    check("full_stall", 32'(in_stall), 32'd1);
    drive(1'b1, 32'd36, 32'd40, 1'b0, 2'd0); tick();
    check("full_ign_count", 32'(count), 32'd8);
    check("full_ign_pc1", out_PC1, 32'd4);

    // count=7 still stalls even with a same-cycle dequeue of two
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'd1);   tick();
    check("c7_count", 32'(count), 32'd7);
    check("c7_stall", 32'(in_stall), 32'd1);
    check("c7_pc1", out_PC1, 32'd8);
    drive(1'b1, 32'd36, 32'd40, 1'b0, 2'd2); tick();
    check("c5_count", 32'(count), 32'd5);
    check("c5_pc1", out_PC1, 32'd16);
    check("c5_pc2", out_PC2, 32'd20);
    drive(1'b1, 32'd36, 32'd40, 1'b0, 2'd0); tick();
    check("c7b_count", 32'(count), 32'd7);
    check("c7b_stall", 32'(in_stall), 32'd1);

    // Drain across the pointer wrap (head 7 -> 0)
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'd2);   tick();
    check("dr5_pc1", out_PC1, 32'd24);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'd3);   tick();
    check("dr3_count", 32'(count), 32'd3);
    check("wrap_pc1", out_PC1, 32'd32);
    check("wrap_pc2", out_PC2, 32'd36);
    check("wrap_inst2", out_inst2, inst_of(32'd36));
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'd2);   tick();
    check("dr1_count", 32'(count), 32'd1);
    check("dr1_pc1", out_PC1, 32'd40);
    check("dr1_v2", 32'(out_valid2), 32'd0);
    check("dr1_pc2", out_PC2, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'd2);   tick();
    check("dr0_count", 32'(count), 32'd0);
    check("dr0_v1", 32'(out_valid1), 32'd0);
    check("dr0_inst1", out_inst1, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'd2);   tick();
    check("under_count", 32'(count), 32'd0);

    // Flush with a correct-path bundle
    drive(1'b1, 32'd4, 32'd8, 1'b0, 2'd0);   tick();
    drive(1'b1, 32'd12, 32'd16, 1'b0, 2'd0); tick();
    drive(1'b1, 32'd20, 32'd24, 1'b0, 2'd0); tick();
    check("pf_count", 32'(count), 32'd6);
    check("pf_pc1", out_PC1, 32'd4);
    drive(1'b1, 32'h104, 32'h108, 1'b1, 2'd2); tick();
`ifdef FQ_BYPASS_EN
    check("fl_byp_count", 32'(count), 32'd0);
    check("fl_byp_v1", 32'(out_valid1), 32'd0);
`else
    check("fl_count", 32'(count), 32'd2);
    check("fl_pc1", out_PC1, 32'h104);
    check("fl_pc2", out_PC2, 32'h108);
    check("fl_inst1", out_inst1, inst_of(32'h104));
    drive(1'b1, 32'h10c, 32'h110, 1'b0, 2'd1); tick();
    check("afl_count", 32'(count), 32'd3);
    check("afl_pc1", out_PC1, 32'h108);
    check("afl_pc2", out_PC2, 32'h10c);
`endif

    // Reset wins over flush and in_valid
    RST = 1'b1;
    drive(1'b1, 32'h200, 32'h204, 1'b1, 2'd0); tick();
    RST = 1'b0;
    check("rst2_count", 32'(count), 32'd0);
    check("rst2_v1", 32'(out_valid1), 32'd0);

    // Flush while stalled drops the bundle
    drive(1'b1, 32'd4, 32'd8, 1'b0, 2'd0);   tick();
    drive(1'b1, 32'd12, 32'd16, 1'b0, 2'd0); tick();
    drive(1'b1, 32'd20, 32'd24, 1'b0, 2'd0); tick();
    drive(1'b1, 32'd28, 32'd32, 1'b0, 2'd0); tick();
    check("sf_pre_count", 32'(count), 32'd8);
    drive(1'b1, 32'h300, 32'h304, 1'b1, 2'd2); tick();
    check("sf_count", 32'(count), 32'd0);
    check("sf_v1", 32'(out_valid1), 32'd0);
    check("sf_stall", 32'(in_stall), 32'd0);

    // Bundle into an empty queue with deq_num=1
    drive(1'b1, 32'h20, 32'h24, 1'b0, 2'd1);
    #1;
`ifdef FQ_BYPASS_EN
    check("byp_pc1", out_PC1, 32'h20);
    check("byp_v2", 32'(out_valid2), 32'd1);
    check("byp_pc2", out_PC2, 32'h24);
    tick();
    check("byp_count", 32'(count), 32'd1);
    check("byp_next_pc1", out_PC1, 32'h24);
`else
    check("nobyp_v1", 32'(out_valid1), 32'd0);
    check("nobyp_pc1", out_PC1, 32'd0);
    tick();
    check("nobyp_count", 32'(count), 32'd2);
    check("nobyp_next_pc1", out_PC1, 32'h20);
`endif
    drive(1'b0, 32'd0, 32'd0, 1'b0, 2'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
